// File: rtl/ttl_gate_exerciser_pkg.sv
// Shared types and constants for the TTL gate exerciser: FSM states, result widths
// and the vector-count rule.
package ttl_gate_exerciser_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam int                FAIL_W   = 8;
   localparam logic [FAIL_W-1:0] FAIL_SAT = 8'hFF;
   localparam int                IDX_W    = 5;

   function automatic int num_vectors(input int width);
      return 2 * width + 2;
   endfunction

endpackage

// File: rtl/ttl_gate_exerciser_vector_gen.sv
// Combinational test-vector table: vector k has the low (k/2) bits set, except the
// final index which is an alternating pattern with bit0 set.
module ttl_vector_gen
   import ttl_gate_exerciser_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic [IDX_W-1:0] k_i,
   output logic [WIDTH-1:0] vec_o
);

   localparam logic [IDX_W-1:0] ALT_IDX = IDX_W'(2 * WIDTH + 1);

   logic [IDX_W-1:0] ones;

   // Clear-then-set of bit i leaves the low i (odd k) or i+1 (even k) bits set.
   always_comb begin
      vec_o = '0;
      ones  = k_i >> 1;
      if (k_i == ALT_IDX) begin
         for (int b = 0; b < WIDTH; b++) vec_o[b] = ((b % 2) == 0);
      end else begin
         for (int b = 0; b < WIDTH; b++) vec_o[b] = (IDX_W'(b) < ones);
      end
   end

endmodule

// File: rtl/ttl_gate_exerciser.sv
// Self-test engine for hex single-input gate packages: drive vector, settle, sample, compare.
// Each vector costs SETTLE_CYCLES+2 cycles; all outputs are registered.
module ttl_gate_exerciser
   import ttl_gate_exerciser_pkg::*;
#(
   parameter int WIDTH         = 6,
   parameter int SETTLE_CYCLES = 4,
   parameter bit EXPECT_INVERT = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [WIDTH-1:0]  stim_out,
   input  logic [WIDTH-1:0]  resp_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [FAIL_W-1:0] fail_count,
   output logic [IDX_W-1:0]  first_fail_index,
   output logic [WIDTH-1:0]  first_fail_resp
);

   localparam int               NUM_VEC  = num_vectors(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
   localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    k_q, k_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0]    stim_q, stim_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic [FAIL_W-1:0]   fail_q, fail_d;
   logic [IDX_W-1:0]    ffi_q, ffi_d;
   logic [WIDTH-1:0]    ffr_q, ffr_d;

   logic [WIDTH-1:0]    vec;
   logic [WIDTH-1:0]    expected;
   logic                mismatch;

   ttl_vector_gen #(.WIDTH(WIDTH)) u_vec (
      .k_i   (k_q),
      .vec_o (vec)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         cnt_q   <= '0;
         stim_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= '0;
         ffi_q   <= '0;
         ffr_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         stim_q  <= stim_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         ffi_q   <= ffi_d;
         ffr_q   <= ffr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      cnt_d    = cnt_q;
      stim_d   = stim_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      fail_d   = fail_q;
      ffi_d    = ffi_q;
      ffr_d    = ffr_q;
      // stim_q still holds vector(k) while sampling; X/Z on resp_in counts as a miss.
      expected = EXPECT_INVERT ? ~stim_q : stim_q;
      mismatch = (resp_in !== expected);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_DRIVE;
               k_d     = '0;
               fail_d  = '0;
               ffi_d   = '0;
               ffr_d   = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end
         ST_DRIVE: begin
            stim_d  = vec;
            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_q == '0) state_d = ST_SAMPLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_SAMPLE: begin
            if (mismatch) begin
               if (fail_q != FAIL_SAT) fail_d = fail_q + FAIL_W'(1);
               if (fail_q == '0) begin
                  ffi_d = k_q;
                  ffr_d = resp_in;
               end
            end
            if (k_q == LAST_IDX) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (fail_d == '0);
            end else begin
               k_d     = k_q + IDX_W'(1);
               state_d = ST_DRIVE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign stim_out         = stim_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign fail_count       = fail_q;
   assign first_fail_index = ffi_q;
   assign first_fail_resp  = ffr_q;

endmodule

// File: tb/tb_ttl_gate_exerciser.sv
// Randomized bench: a delayed/faulty gate model feeds the exerciser, a timeline
// reference model predicts the run verdict from the vector rules and schedule.
module tb_ttl_gate_exerciser;

   localparam int W = 6;
   localparam int S = 4;
   localparam int P = S + 2;
   localparam int N = 2 * W + 2;

   logic         clk;
   logic         reset;
   logic         start;
   logic [W-1:0] stim_out;
   logic [W-1:0] resp_in;
   logic         busy, done, pass;
   logic [7:0]   fail_count;
   logic [4:0]   first_fail_index;
   logic [W-1:0] first_fail_resp;

   // Gate environment: inverter or buffer, stuck-at masks, delay in clock edges.
   bit           gate_inv;
   logic [W-1:0] sa0, sa1;
   int           dly;
   logic [W-1:0] dl [0:7];
   logic [W-1:0] model_prior;

   int n_checks;
   int n_errors;

   ttl_gate_exerciser dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .stim_out         (stim_out),
      .resp_in          (resp_in),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .fail_count       (fail_count),
      .first_fail_index (first_fail_index),
      .first_fail_resp  (first_fail_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // dl[j] holds stim_out as it stood after the j-th most recent rising edge.
   always @(negedge clk) begin
      for (int j = 7; j > 0; j--) dl[j] = dl[j-1];
      dl[0] = stim_out;
   end

   assign resp_in = ((gate_inv ? ~dl[dly] : dl[dly]) & ~sa0) | sa1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_vec(input int k);
      logic [W-1:0] v;
      int           m;
      v = '0;
      if (k == 2 * W + 1) begin
         for (int b = 0; b < W; b += 2) v[b] = 1'b1;
      end else begin
         m = (1 << (k / 2)) - 1;
         v = m[W-1:0];
      end
      return v;
   endfunction

   function automatic logic [W-1:0] gate_f(input logic [W-1:0] x);
      return ((gate_inv ? ~x : x) & ~sa0) | sa1;
   endfunction

   task automatic do_run(input bit extra, input bit hold);
      int           e_cnt, e_ffi, e, j;
      logic [W-1:0] e_ffr, sv, obs;
      e_cnt = 0;
      e_ffi = 0;
      e_ffr = '0;
      // Vector k is driven at edge k*P+1 and sampled at edge (k+1)*P; the gate
      // shows the stimulus from dly edges before the last pre-sample edge.
      for (int k = 0; k < N; k++) begin
         e   = (k + 1) * P - 1 - dly;
         j   = (e - 1) / P;
         sv  = (e < 1) ? model_prior : ref_vec(j);
         obs = gate_f(sv);
         if (obs != ~ref_vec(k)) begin
            if (e_cnt == 0) begin
               e_ffi = k;
               e_ffr = obs;
            end
            e_cnt++;
         end
      end

      @(negedge clk);
      start = 1'b1;
      for (int c = 0; c <= N * P; c++) begin
         @(posedge clk);
         @(negedge clk);
         start = (hold && c < 3) ? 1'b1 : 1'b0;
         if (extra && (c == 10 || c == 50)) start = 1'b1;
         if (c == 0) begin
            check_eq("busy_after_start", busy, 1);
            check_eq("done_after_start", done, 0);
            check_eq("fail_cleared", fail_count, 0);
         end
         if (c >= 1 && ((c - 1) % P) == 0)
            check_eq($sformatf("stim_k%0d", (c - 1) / P), stim_out, ref_vec((c - 1) / P));
         if (c == N * P - 1) check_eq("done_early", done, 0);
         if (c == N * P) begin
            check_eq("done_at_end", done, 1);
            check_eq("busy_at_end", busy, 0);
            check_eq("pass", pass, (e_cnt == 0) ? 1 : 0);
            check_eq("fail_count", fail_count, e_cnt);
            check_eq("first_fail_index", first_fail_index, e_ffi);
            check_eq("first_fail_resp", first_fail_resp, e_ffr);
         end
      end
      model_prior = ref_vec(N - 1);
   endtask

   task automatic reset_mid_run();
      @(negedge clk);
      start = 1'b1;
      for (int c = 0; c <= 30; c++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
      end
      reset = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_stim", stim_out, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_pass", pass, 0);
      check_eq("rst_fail", fail_count, 0);
      check_eq("rst_ffi", first_fail_index, 0);
      check_eq("rst_ffr", first_fail_resp, 0);
      reset = 1'b0;
      start = 1'b0;
      model_prior = '0;
      @(negedge clk);
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      reset       = 1'b1;
      start       = 1'b0;
      gate_inv    = 1'b1;
      sa0         = '0;
      sa1         = '0;
      dly         = 0;
      model_prior = '0;
      for (int j = 0; j < 8; j++) dl[j] = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset_stim", stim_out, 0);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_done", done, 0);
      check_eq("reset_pass", pass, 0);
      check_eq("reset_fail", fail_count, 0);
      check_eq("reset_ffi", first_fail_index, 0);
      check_eq("reset_ffr", first_fail_resp, 0);
      reset = 1'b0;
      @(negedge clk);

      // Good inverter within the settle window.
      dly = $urandom_range(0, S);
      do_run(1'b0, 1'b0);

      // Y3 stuck-at-1.
      sa1 = 6'b000100;
      dly = 1;
      do_run(1'b0, 1'b0);
      sa1 = '0;

      // Buffer on an inverter-expecting exerciser: every vector fails.
      gate_inv = 1'b0;
      do_run(1'b0, 1'b0);
      gate_inv = 1'b1;

      // Start re-pulsed mid-run and held at start-up: ignored while busy.
      dly = 2;
      do_run(1'b1, 1'b1);

      reset_mid_run();
      do_run(1'b0, 1'b0);

      // Gate slower than the settle window: sample catches the previous vector.
      dly = S + 1;
      do_run(1'b0, 1'b0);

      for (int r = 0; r < 8; r++) begin
         gate_inv = ($urandom_range(0, 4) != 0);
         sa0      = ($urandom_range(0, 2) == 0) ? (6'($urandom) & 6'($urandom)) : '0;
         sa1      = ($urandom_range(0, 2) == 0) ? (6'($urandom) & 6'($urandom)) : '0;
         dly      = $urandom_range(0, S + 2);
         do_run($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
